// File: rtl/icache_line_fetcher.sv
// -----------------------------------------------------------------------------
// icache_line_fetcher
//
// Refills one 32-byte instruction-cache line by reading eight 32-bit words from
// a backing memory over a simple req/ack handshake. The assembled line is
// presented for a single cycle on the return port and then held.
//
// Ports
//   clk                     rising-edge clock
//   reset                   asynchronous active-high reset
//   cache_mem_read_en       refill request (level, held until the line returns)
//   cache_mem_read_addr     physical miss address
//   mem_icache_return_en    one-cycle line-valid pulse
//   mem_icache_return_data  packed line, bank k at bits [32k+31:32k]
//   ram_req                 word read request to backing memory
//   ram_addr                byte address of the requested word
//   ram_ack                 word-valid strobe, sampled only while ram_req=1
//   ram_rdata               word data, valid with ram_ack
//
// Configuration
//   ICACHE_FETCH_CRITICAL_FIRST_EN  when defined, the fetch starts at the
//       missing word and wraps around the line; otherwise banks go 0..7.
//       Bank placement in the returned line is the same either way.
// -----------------------------------------------------------------------------
module icache_line_fetcher (
    input  logic         clk,
    input  logic         reset,
    input  logic         cache_mem_read_en,
    input  logic [31:0]  cache_mem_read_addr,
    output logic         mem_icache_return_en,
    output logic [255:0] mem_icache_return_data,
    output logic         ram_req,
    output logic [31:0]  ram_addr,
    input  logic         ram_ack,
    input  logic [31:0]  ram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        RESP,
        HOLD
    } state_t;

    state_t         state_q, state_d;
    logic [26:0]    base_q, base_d;     // line address, addr[31:5]
    logic [2:0]     cnt_q, cnt_d;       // words accepted so far
    logic [255:0]   line_q, line_d;     // line under assembly (never visible)
    logic [255:0]   rdata_q, rdata_d;   // last completed line
    logic [2:0]     bank;               // bank addressed by the current fetch

`ifdef ICACHE_FETCH_CRITICAL_FIRST_EN
    logic [2:0]     start_q, start_d;   // critical word index, addr[4:2]

    // 3-bit add wraps the fetch order around the line.
    assign bank = start_q + cnt_q;
`else
    assign bank = cnt_q;
`endif

    // Byte-offset bits only matter for the critical-first order.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cache_mem_read_addr[4:0];

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        rdata_d = rdata_q;
`ifdef ICACHE_FETCH_CRITICAL_FIRST_EN
        start_d = start_q;
`endif

        case (state_q)
            IDLE: begin
                if (cache_mem_read_en) begin
                    base_d  = cache_mem_read_addr[31:5];
`ifdef ICACHE_FETCH_CRITICAL_FIRST_EN
                    start_d = cache_mem_read_addr[4:2];
`endif
                    cnt_d   = 3'd0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // Request inputs are deliberately not looked at here: the
                // latched miss completes even if the cache withdraws it.
                if (ram_ack) begin
                    line_d[{bank, 5'd0} +: 32] = ram_rdata;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        // Publish the whole line at once, including this word.
                        rdata_d = line_d;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = HOLD;
            end
            HOLD: begin
                // Wait for the cache to drop its level request so the same
                // miss is not fetched twice.
                if (!cache_mem_read_en) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the line buffer is reset along with the control state so a line
    // abandoned by reset can never leak into a later return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            line_q  <= '0;
            rdata_q <= '0;
`ifdef ICACHE_FETCH_CRITICAL_FIRST_EN
            start_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            rdata_q <= rdata_d;
`ifdef ICACHE_FETCH_CRITICAL_FIRST_EN
            start_q <= start_d;
`endif
        end
    end

    // Outputs decode straight from registered state, so reset clears them
    // immediately without waiting for a clock.
    assign ram_req                = (state_q == FETCH);
    assign ram_addr               = (state_q == FETCH) ? {base_q, bank, 2'b00} : 32'd0;
    assign mem_icache_return_en   = (state_q == RESP);
    assign mem_icache_return_data = rdata_q;

endmodule

// File: tb/tb_icache_line_fetcher.sv
// -----------------------------------------------------------------------------
// tb_icache_line_fetcher
//
// Randomized self-checking bench for icache_line_fetcher. The backing memory is
// a pure function of the byte address; the expected fetch order, line contents
// and return timing come from a small address-level model of a line refill.
// -----------------------------------------------------------------------------
module tb_icache_line_fetcher;

    logic         clk = 1'b0;
    logic         reset;
    logic         cache_mem_read_en;
    logic [31:0]  cache_mem_read_addr;
    logic         mem_icache_return_en;
    logic [255:0] mem_icache_return_data;
    logic         ram_req;
    logic [31:0]  ram_addr;
    logic         ram_ack;
    logic [31:0]  ram_rdata;

    int           checks = 0;
    int           errors = 0;
    bit           simple_data;
    logic [31:0]  seed_key;
    logic [255:0] last_line;

    icache_line_fetcher dut (
        .clk                    (clk),
        .reset                  (reset),
        .cache_mem_read_en      (cache_mem_read_en),
        .cache_mem_read_addr    (cache_mem_read_addr),
        .mem_icache_return_en   (mem_icache_return_en),
        .mem_icache_return_data (mem_icache_return_data),
        .ram_req                (ram_req),
        .ram_addr               (ram_addr),
        .ram_ack                (ram_ack),
        .ram_rdata              (ram_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Backing memory contents as a function of byte address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (simple_data) return 32'h100 + {29'd0, a[4:2]};
        return (a * 32'h9E37_79B1) ^ seed_key;
    endfunction

    // Address of the i-th word fetched for a miss at a.
    function automatic logic [31:0] exp_addr(input logic [31:0] a, input int i);
        logic [2:0] b;
`ifdef ICACHE_FETCH_CRITICAL_FIRST_EN
        b = a[4:2] + 3'(i);
`else
        b = 3'(i);
`endif
        return {a[31:5], b, 2'b00};
    endfunction

    // Line a miss at a must return: bank k is the word at line base + 4k.
    function automatic logic [255:0] exp_line(input logic [31:0] a);
        logic [255:0] l;
        l = '0;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = mem_word({a[31:5], 3'(k), 2'b00});
        return l;
    endfunction

    // One refill. wait_mode: 0 always ack, 1 three wait cycles per word,
    // 2 random acks. hold = cycles read_en stays high after the return pulse.
    task automatic do_req(input logic [31:0] a, input int wait_mode, input int hold,
                          input bit poke_addr, input bit drop_en);
        int acks;
        int waited;
        int cycles;
        bit ack;
        @(negedge clk);
        cache_mem_read_en   = 1'b1;
        cache_mem_read_addr = a;
        ram_ack             = 1'b0;
        acks   = 0;
        waited = 0;
        cycles = 0;
        while (acks < 8 && cycles < 400) begin
            @(negedge clk);
            cycles++;
            check("ram_req_fetch", ram_req, 1);
            check("ram_addr", ram_addr, exp_addr(a, acks));
            check("early_return_en", mem_icache_return_en, 0);
            check("partial_data", mem_icache_return_data, last_line);
            if (poke_addr && acks == 3) cache_mem_read_addr = 32'h80;
            if (drop_en && acks == 2) cache_mem_read_en = 1'b0;
            case (wait_mode)
                0:       ack = 1'b1;
                1:       ack = (waited == 3);
                default: ack = ($urandom_range(0, 2) == 0);
            endcase
            if (ack) begin
                ram_ack   = 1'b1;
                ram_rdata = mem_word(exp_addr(a, acks));
                acks++;
                waited = 0;
            end else begin
                ram_ack   = 1'b0;
                ram_rdata = $urandom;
                waited++;
            end
        end
        check("fetch_timeout", acks, 8);
        if (wait_mode == 0) check("fetch_cycles", cycles, 8);
        if (wait_mode == 1) check("fetch_cycles", cycles, 32);
        @(negedge clk);
        ram_ack   = 1'b0;
        last_line = exp_line(a);
        check("return_en", mem_icache_return_en, 1);
        check("return_data", mem_icache_return_data, last_line);
        check("ram_req_resp", ram_req, 0);
        repeat (hold) begin
            @(negedge clk);
            check("hold_return_en", mem_icache_return_en, 0);
            check("hold_ram_req", ram_req, 0);
            check("hold_data", mem_icache_return_data, last_line);
        end
        cache_mem_read_en = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("idle_return_en", mem_icache_return_en, 0);
            check("idle_ram_req", ram_req, 0);
            check("idle_data", mem_icache_return_data, last_line);
        end
    endtask

    // Reset arriving after four acks must wipe the outputs at once and never
    // lead to a return pulse.
    task automatic reset_mid_fetch(input logic [31:0] a);
        @(negedge clk);
        cache_mem_read_en   = 1'b1;
        cache_mem_read_addr = a;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_ram_addr", ram_addr, exp_addr(a, i));
            ram_ack   = 1'b1;
            ram_rdata = mem_word(exp_addr(a, i));
        end
        @(negedge clk);
        check("rst_ram_addr5", ram_addr, exp_addr(a, 4));
        ram_ack           = 1'b0;
        cache_mem_read_en = 1'b0;
        #1 reset = 1'b1;
        #1;
        last_line = '0;
        check("rst_async_ram_req", ram_req, 0);
        check("rst_async_ram_addr", ram_addr, 0);
        check("rst_async_return_en", mem_icache_return_en, 0);
        check("rst_async_data", mem_icache_return_data, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("post_rst_return_en", mem_icache_return_en, 0);
            check("post_rst_ram_req", ram_req, 0);
            check("post_rst_data", mem_icache_return_data, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset               = 1'b0;
        cache_mem_read_en   = 1'b0;
        cache_mem_read_addr = '0;
        ram_ack             = 1'b0;
        ram_rdata           = '0;
        seed_key            = $urandom;
        simple_data         = 1'b1;
        last_line           = '0;

        #2 reset = 1'b1;
        #1;
        check("reset_ram_req", ram_req, 0);
        check("reset_ram_addr", ram_addr, 0);
        check("reset_return_en", mem_icache_return_en, 0);
        check("reset_data", mem_icache_return_data, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        do_req(32'h40, 0, 0, 1'b0, 1'b0);          // sequential fill, 0x100+k
        simple_data = 1'b0;
        do_req(32'h54, 0, 0, 1'b0, 1'b0);          // mid-line miss
        do_req($urandom, 1, 0, 1'b0, 1'b0);        // three waits per word
        do_req($urandom, 0, 5, 1'b0, 1'b0);        // request held after return
        reset_mid_fetch(32'h40);
        do_req(32'h40, 0, 0, 1'b0, 1'b0);          // fresh refill after reset
        do_req(32'h40, 2, 1, 1'b1, 1'b0);          // address moves to 0x80
        do_req($urandom, 2, 2, 1'b0, 1'b1);        // read_en dropped mid-fetch
        do_req(32'hFFFF_FFFC, 0, 0, 1'b0, 1'b0);   // top-of-memory line
        for (int n = 0; n < 30; n++) begin
            do_req($urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
